// File: rtl/id_ex_stage_pkg.sv
// Shared types for the ID/EX stage: datapath widths, ALU select codes and
// the EX pipeline register layout.
package id_ex_stage_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int REG_ADDR_WIDTH = 5;

  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SUB  = 4'h1;
  localparam logic [3:0] ALU_AND  = 4'h2;
  localparam logic [3:0] ALU_OR   = 4'h3;
  localparam logic [3:0] ALU_XOR  = 4'h4;
  localparam logic [3:0] ALU_SLL  = 4'h5;
  localparam logic [3:0] ALU_SRL  = 4'h6;
  localparam logic [3:0] ALU_SRA  = 4'h7;
  localparam logic [3:0] ALU_SLT  = 4'h8;
  localparam logic [3:0] ALU_SLTU = 4'h9;
  localparam logic [3:0] ALU_NOP  = 4'hF;

  typedef struct packed {
    logic                      valid;
    logic [DATA_WIDTH-1:0]     pc;
    logic [DATA_WIDTH-1:0]     a;
    logic [DATA_WIDTH-1:0]     b;
    logic [3:0]                alu_sel;
    logic [DATA_WIDTH-1:0]     rs2_fwd;
    logic [REG_ADDR_WIDTH-1:0] rd_addr;
    logic                      rd_we;
    logic                      is_load;
  } ex_reg_t;

  // A bubble also zeroes the data fields so reset and bubble look identical.
  function automatic ex_reg_t bubble();
    ex_reg_t b;
    b         = '0;
    b.alu_sel = ALU_NOP;
    return b;
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-side, forwarding-side and EX-side signals of the ID/EX stage.
interface id_ex_stage_if;
  import id_ex_stage_pkg::*;

  logic                      id_valid;
  logic [DATA_WIDTH-1:0]     id_pc;
  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr;
  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr;
  logic [DATA_WIDTH-1:0]     id_rs1_data;
  logic [DATA_WIDTH-1:0]     id_rs2_data;
  logic [DATA_WIDTH-1:0]     id_imm;
  logic                      id_use_pc_a;
  logic                      id_use_imm_b;
  logic [3:0]                id_alu_sel;
  logic [REG_ADDR_WIDTH-1:0] id_rd_addr;
  logic                      id_rd_we;
  logic                      id_is_load;
  logic [DATA_WIDTH-1:0]     ex_result;
  logic [REG_ADDR_WIDTH-1:0] mem_rd_addr;
  logic                      mem_rd_we;
  logic [DATA_WIDTH-1:0]     mem_data;
  logic                      stall;
  logic                      flush;

  logic                      id_stall;
  logic                      ex_valid;
  logic [DATA_WIDTH-1:0]     ex_pc;
  logic [DATA_WIDTH-1:0]     ex_a;
  logic [DATA_WIDTH-1:0]     ex_b;
  logic [3:0]                ex_alu_sel;
  logic [DATA_WIDTH-1:0]     ex_rs2_fwd;
  logic [REG_ADDR_WIDTH-1:0] ex_rd_addr;
  logic                      ex_rd_we;
  logic                      ex_is_load;

  modport master (
    output id_valid, id_pc, id_rs1_addr, id_rs2_addr, id_rs1_data, id_rs2_data,
           id_imm, id_use_pc_a, id_use_imm_b, id_alu_sel, id_rd_addr, id_rd_we,
           id_is_load, ex_result, mem_rd_addr, mem_rd_we, mem_data, stall, flush,
    input  id_stall, ex_valid, ex_pc, ex_a, ex_b, ex_alu_sel, ex_rs2_fwd,
           ex_rd_addr, ex_rd_we, ex_is_load
  );

  modport slave (
    input  id_valid, id_pc, id_rs1_addr, id_rs2_addr, id_rs1_data, id_rs2_data,
           id_imm, id_use_pc_a, id_use_imm_b, id_alu_sel, id_rd_addr, id_rd_we,
           id_is_load, ex_result, mem_rd_addr, mem_rd_we, mem_data, stall, flush,
    output id_stall, ex_valid, ex_pc, ex_a, ex_b, ex_alu_sel, ex_rs2_fwd,
           ex_rd_addr, ex_rd_we, ex_is_load
  );

endinterface

// File: rtl/id_ex_stage_operand_fwd_mux.sv
// Per-operand forwarding select: EX result beats MEM data beats register file;
// x0 always reads the register file.
module operand_fwd_mux
  import id_ex_stage_pkg::*;
(
  input  logic [REG_ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0]     rf_data,
  input  logic                      ex_valid,
  input  logic                      ex_rd_we,
  input  logic                      ex_is_load,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd_addr,
  input  logic [DATA_WIDTH-1:0]     ex_result,
  input  logic                      mem_rd_we,
  input  logic [REG_ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0]     mem_data,
  output logic [DATA_WIDTH-1:0]     value
);

  // A load in EX has no data yet; that case is covered by the load-use stall.
  always_comb begin
    value = rf_data;
    if (addr != '0 && ex_valid && ex_rd_we && !ex_is_load && ex_rd_addr == addr)
      value = ex_result;
    else if (addr != '0 && mem_rd_we && mem_rd_addr == addr)
      value = mem_data;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM operand forwarding and load-use
// bubble insertion.
module id_ex_stage
  import id_ex_stage_pkg::*;
(
  input logic          clk,
  input logic          rst,
  id_ex_stage_if.slave bus
);

  ex_reg_t               ex_q;
  ex_reg_t               capture;
  logic [DATA_WIDTH-1:0] fwd_rs1;
  logic [DATA_WIDTH-1:0] fwd_rs2;
  logic                  hazard;

  operand_fwd_mux u_fwd_rs1 (
    .addr        (bus.id_rs1_addr),
    .rf_data     (bus.id_rs1_data),
    .ex_valid    (ex_q.valid),
    .ex_rd_we    (ex_q.rd_we),
    .ex_is_load  (ex_q.is_load),
    .ex_rd_addr  (ex_q.rd_addr),
    .ex_result   (bus.ex_result),
    .mem_rd_we   (bus.mem_rd_we),
    .mem_rd_addr (bus.mem_rd_addr),
    .mem_data    (bus.mem_data),
    .value       (fwd_rs1)
  );

  operand_fwd_mux u_fwd_rs2 (
    .addr        (bus.id_rs2_addr),
    .rf_data     (bus.id_rs2_data),
    .ex_valid    (ex_q.valid),
    .ex_rd_we    (ex_q.rd_we),
    .ex_is_load  (ex_q.is_load),
    .ex_rd_addr  (ex_q.rd_addr),
    .ex_result   (bus.ex_result),
    .mem_rd_we   (bus.mem_rd_we),
    .mem_rd_addr (bus.mem_rd_addr),
    .mem_data    (bus.mem_data),
    .value       (fwd_rs2)
  );

  // rs2 is compared even for immediate forms; cheaper than decoding its use.
  assign hazard = bus.id_valid & ex_q.valid & ex_q.is_load & (ex_q.rd_addr != '0) &
                  ((ex_q.rd_addr == bus.id_rs1_addr) | (ex_q.rd_addr == bus.id_rs2_addr));

  assign bus.id_stall = hazard & ~bus.flush & ~bus.stall;

  always_comb begin
    capture         = '0;
    capture.valid   = 1'b1;
    capture.pc      = bus.id_pc;
    capture.a       = bus.id_use_pc_a ? bus.id_pc : fwd_rs1;
    capture.b       = bus.id_use_imm_b ? bus.id_imm : fwd_rs2;
    capture.alu_sel = bus.id_alu_sel;
    capture.rs2_fwd = fwd_rs2;
    capture.rd_addr = bus.id_rd_addr;
    capture.rd_we   = bus.id_rd_we;
    capture.is_load = bus.id_is_load;
  end

  // Flush beats stall; a stall holds everything so forwarding sources stay put.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ex_q <= bubble();
    else if (bus.flush)
      ex_q <= bubble();
    else if (!bus.stall) begin
      if (hazard)
        ex_q <= bubble();
      else if (bus.id_valid)
        ex_q <= capture;
      else
        ex_q <= bubble();
    end
  end

  assign bus.ex_valid   = ex_q.valid;
  assign bus.ex_pc      = ex_q.pc;
  assign bus.ex_a       = ex_q.a;
  assign bus.ex_b       = ex_q.b;
  assign bus.ex_alu_sel = ex_q.alu_sel;
  assign bus.ex_rs2_fwd = ex_q.rs2_fwd;
  assign bus.ex_rd_addr = ex_q.rd_addr;
  assign bus.ex_rd_we   = ex_q.rd_we;
  assign bus.ex_is_load = ex_q.is_load;

endmodule
